johnson_seq_ctrl: RTL and testbench

// - Sequencer for the Johnson-counter datapath.
// - Accepts one-at-a-time commands over a valid/ready handshake.
// - Generates prescaled single-cycle step strobes, plus direction and clear controls, for the counter register.
// - Sits between the TT pin wrapper (ui_in/uio_in decode) and the Johnson register; owns all sequencing state.

---
 rtl/johnson_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
// Command sequencer for the Johnson-counter datapath: prescaled step strobes, direction and clear.
// Optional phase tracking and wrap pulse when JSC_WRAP_DETECT_EN is defined.
module johnson_seq_ctrl #(
  parameter int unsigned JC_WIDTH = 8,
  parameter int unsigned PRESC_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       jc_step,
  output logic       jc_dir,
  output logic       jc_clr,
  output logic       busy,
  output logic       done,
  output logic [7:0] steps_left,
  output logic       wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST, S_CLR} state_e;

  localparam logic [2:0] OP_CLEAR     = 3'd1;
  localparam logic [2:0] OP_RUN       = 3'd2;
  localparam logic [2:0] OP_BURST     = 3'd3;
  localparam logic [2:0] OP_STOP      = 3'd4;
  localparam logic [2:0] OP_SET_DIR   = 3'd5;
  localparam logic [2:0] OP_SET_PRESC = 3'd6;

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_reg_q, presc_reg_d;
  logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
  logic                 jc_dir_q, jc_dir_d;
  logic [7:0]           steps_left_q, steps_left_d;
  logic                 jc_step_q, jc_step_d;
  logic                 jc_clr_q, jc_clr_d;
  logic                 done_q, done_d;
  logic                 zb_q, zb_d;
  logic                 accept;
  logic                 tick_en;

  assign cmd_ready  = rst_n & ena & ((state_q == S_IDLE) | (state_q == S_RUN));
  assign accept     = cmd_valid & cmd_ready;
  assign jc_step    = jc_step_q;
  assign jc_dir     = jc_dir_q;
  assign jc_clr     = jc_clr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign steps_left = steps_left_q;

  // Command decode, prescaler tick and burst countdown; ena=0 holds everything and clears strobes
  always_comb begin
    state_d      = state_q;
    presc_reg_d  = presc_reg_q;
    presc_cnt_d  = presc_cnt_q;
    jc_dir_d     = jc_dir_q;
    steps_left_d = steps_left_q;
    jc_step_d    = 1'b0;
    jc_clr_d     = 1'b0;
    done_d       = 1'b0;
    zb_d         = zb_q;
    tick_en      = 1'b0;
    if (ena) begin
      tick_en = (state_q == S_RUN) || (state_q == S_BURST);
      zb_d    = 1'b0;
      if (zb_q) done_d = 1'b1;
      if (accept) begin
        case (cmd_op)
          OP_CLEAR: begin
            state_d  = S_CLR;
            jc_clr_d = 1'b1;
            tick_en  = 1'b0;
          end
          OP_RUN: begin
            state_d     = S_RUN;
            presc_cnt_d = '0;
            tick_en     = 1'b0;
          end
          OP_BURST: begin
            steps_left_d = cmd_arg;
            presc_cnt_d  = '0;
            tick_en      = 1'b0;
            state_d      = (cmd_arg != 8'd0) ? S_BURST : S_IDLE;
            zb_d         = (cmd_arg == 8'd0);
          end
          OP_STOP: begin
            state_d = S_IDLE;
            tick_en = 1'b0;
          end
          OP_SET_DIR: jc_dir_d = cmd_arg[0];
          OP_SET_PRESC: begin
            presc_reg_d = PRESC_W'(cmd_arg);
            presc_cnt_d = '0;
            tick_en     = 1'b0;
          end
          default: ;
        endcase
      end
      if (state_q == S_CLR) begin
        state_d     = S_IDLE;
        presc_cnt_d = '0;
      end
      if (tick_en) begin
        if (presc_cnt_q == presc_reg_q) begin
          presc_cnt_d = '0;
          jc_step_d   = 1'b1;
          if (state_q == S_BURST) begin
            steps_left_d = steps_left_q - 8'd1;
            if (steps_left_q == 8'd1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_reg_q  <= '0;
      presc_cnt_q  <= '0;
      jc_dir_q     <= 1'b1;
      steps_left_q <= '0;
      jc_step_q    <= 1'b0;
      jc_clr_q     <= 1'b0;
      done_q       <= 1'b0;
      zb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_reg_q  <= presc_reg_d;
      presc_cnt_q  <= presc_cnt_d;
      jc_dir_q     <= jc_dir_d;
      steps_left_q <= steps_left_d;
      jc_step_q    <= jc_step_d;
      jc_clr_q     <= jc_clr_d;
      done_q       <= done_d;
      zb_q         <= zb_d;
    end
  end

`ifdef JSC_WRAP_DETECT_EN
  localparam int unsigned POS_W = $clog2(2 * JC_WIDTH);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(2 * JC_WIDTH - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;

  assign wrap = wrap_q;

  // Phase follows each issued step in the current direction; wrap marks arrival at phase 0
  always_comb begin
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (ena && (state_q == S_CLR)) begin
      pos_d = '0;
    end else if (jc_step_d) begin
      if (jc_dir_q) pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
      else          pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
      wrap_d = (pos_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
    end
  end
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed self-checking bench for johnson_seq_ctrl; wrap checks follow JSC_WRAP_DETECT_EN.
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       jc_step;
  logic       jc_dir;
  logic       jc_clr;
  logic       busy;
  logic       done;
  logic [7:0] steps_left;
  logic       wrap;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] OP_NOP = 3'd0, OP_CLEAR = 3'd1, OP_RUN = 3'd2, OP_BURST = 3'd3;
  localparam logic [2:0] OP_STOP = 3'd4, OP_SET_DIR = 3'd5, OP_SET_PRESC = 3'd6;

  johnson_seq_ctrl #(.JC_WIDTH(8), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .jc_step(jc_step), .jc_dir(jc_dir), .jc_clr(jc_clr), .busy(busy), .done(done),
    .steps_left(steps_left), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = 8'd0;
  endtask

  initial begin
    int en_cyc;
    int nsteps;
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 8'd0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step", 32'(jc_step), 0);
    chk("rst_dir", 32'(jc_dir), 1);
    chk("rst_steps_left", 32'(steps_left), 0);
    chk("rst_done_wrap_clr", 32'({done, wrap, jc_clr}), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(cmd_ready), 1);

    // BURST 5 at prescale 0
    send(OP_SET_PRESC, 8'd0);
    send(OP_BURST, 8'd5);
    chk("b5_accept_step", 32'(jc_step), 0);
    chk("b5_busy", 32'(busy), 1);
    chk("b5_ready", 32'(cmd_ready), 0);
    chk("b5_steps_left0", 32'(steps_left), 5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("b5_step", 32'(jc_step), 1);
      chk("b5_steps_left", 32'(steps_left), 32'(5 - i));
      chk("b5_done", 32'(done), (i == 5) ? 1 : 0);
      chk("b5_wrap", 32'(wrap), 0);
    end
    tick();
    chk("b5_after_step", 32'(jc_step), 0);
    chk("b5_after_busy", 32'(busy), 0);
    chk("b5_after_done", 32'(done), 0);

    // RUN at prescale 3, STOP after 20 cycles
    send(OP_SET_PRESC, 8'd3);
    send(OP_RUN, 8'd0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("run4_step", 32'(jc_step), (c % 4 == 0) ? 1 : 0);
      chk("run4_busy", 32'(busy), 1);
    end
    send(OP_STOP, 8'd0);
    chk("stop_busy", 32'(busy), 0);
    nsteps = 32'(jc_step);
    for (int i = 0; i < 8; i++) begin
      tick();
      nsteps += 32'(jc_step);
    end
    chk("stop_no_steps", 32'(nsteps), 0);

    // BURST 0
    send(OP_BURST, 8'd0);
    chk("b0_done_early", 32'(done), 0);
    chk("b0_ready", 32'(cmd_ready), 1);
    tick();
    chk("b0_done", 32'(done), 1);
    chk("b0_step", 32'(jc_step), 0);
    chk("b0_ready2", 32'(cmd_ready), 1);
    tick();
    chk("b0_done_clear", 32'(done), 0);

    // BURST 10 at prescale 1 with ena low for 7 cycles
    send(OP_SET_PRESC, 8'd1);
    send(OP_BURST, 8'd10);
    en_cyc = 0;
    nsteps = 0;
    for (int t = 1; t <= 27; t++) begin
      ena = !(t >= 6 && t <= 12);
      tick();
      if (ena) en_cyc++;
      nsteps += 32'(jc_step);
      chk("b10_step", 32'(jc_step), (ena && en_cyc % 2 == 0 && en_cyc <= 20) ? 1 : 0);
      chk("b10_ready", 32'(cmd_ready), (ena && en_cyc >= 20) ? 1 : 0);
      chk("b10_done", 32'(done), (ena && en_cyc == 20) ? 1 : 0);
    end
    chk("b10_total", 32'(nsteps), 10);
    chk("b10_steps_left", 32'(steps_left), 0);
    ena = 1'b1;

    // CLEAR while running
    send(OP_SET_PRESC, 8'd0);
    send(OP_RUN, 8'd0);
    tick();
    chk("clr_run_step", 32'(jc_step), 1);
    send(OP_CLEAR, 8'd0);
    chk("clr_pulse", 32'(jc_clr), 1);
    chk("clr_no_step", 32'(jc_step), 0);
    chk("clr_busy", 32'(busy), 1);
    chk("clr_ready", 32'(cmd_ready), 0);
    tick();
    chk("clr_pulse_end", 32'(jc_clr), 0);
    chk("clr_idle", 32'(busy), 0);
    chk("clr_idle_step", 32'(jc_step), 0);
    chk("clr_idle_ready", 32'(cmd_ready), 1);

    // Direction
    send(OP_SET_DIR, 8'd0);
    chk("dir0", 32'(jc_dir), 0);
    send(OP_SET_DIR, 8'd1);
    chk("dir1", 32'(jc_dir), 1);

    // STOP on an edge that would otherwise tick
    send(OP_RUN, 8'd0);
    tick();
    chk("stop_tick_run", 32'(jc_step), 1);
    send(OP_STOP, 8'd0);
    chk("stop_tick_suppressed", 32'(jc_step), 0);
    chk("stop_tick_busy", 32'(busy), 0);

    // Reset mid-burst
    send(OP_BURST, 8'd200);
    tick(); tick(); tick();
    chk("mid_burst_step", 32'(jc_step), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_step", 32'(jc_step), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_steps_left", 32'(steps_left), 0);
    chk("arst_ready", 32'(cmd_ready), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_post_done", 32'(done), 0);
    chk("arst_post_busy", 32'(busy), 0);

`ifdef JSC_WRAP_DETECT_EN
    send(OP_SET_PRESC, 8'd0);
    send(OP_BURST, 8'd16);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("w16_wrap", 32'(wrap), (i == 16) ? 1 : 0);
    end
    send(OP_SET_DIR, 8'd0);
    send(OP_BURST, 8'd1);
    tick();
    chk("wdown_step", 32'(jc_step), 1);
    chk("wdown_wrap", 32'(wrap), 0);
    send(OP_SET_DIR, 8'd1);
    send(OP_BURST, 8'd1);
    tick();
    chk("wup_wrap", 32'(wrap), 1);
`else
    send(OP_RUN, 8'd0);
    nsteps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nsteps += 32'(wrap);
    end
    chk("wrap_tied_low", 32'(nsteps), 0);
    send(OP_STOP, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
